alu_arbiter: RTL

//  Shares one combinational 8-bit ALU (op 0..6: add, sub, and, or, xor, shl1, shr1) between two requesters.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// Accepts one op at a time, registers the ALU result and returns it tagged with the requester id.
module alu_arbiter #(
    parameter int                DATA_W = 8,
    parameter int                OP_W   = 3,
    parameter logic [OP_W-1:0]   BAD_OP = 3'b111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [OP_W-1:0]   r0_op,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [OP_W-1:0]   r1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_id_q, rsp_id_d;
    logic                rsp_err_q, rsp_err_d;
    logic                gnt;
    logic                gnt_vld;
    logic                bad_op;

    // On a tie the requester that did not win last time is chosen.
    assign gnt     = (r0_valid && r1_valid) ? ~last_q : r1_valid;
    assign gnt_vld = r0_valid || r1_valid;
    assign bad_op  = (alu_op_q == BAD_OP);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld && !rst) begin
                    r0_ready = ~gnt;
                    r1_ready = gnt;
                    alu_a_d  = gnt ? r1_a  : r0_a;
                    alu_b_d  = gnt ? r1_b  : r0_b;
                    alu_op_d = gnt ? r1_op : r0_op;
                    id_d     = gnt;
                    last_d   = gnt;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // ALU inputs have been stable for a full cycle; capture its output.
                rsp_data_d  = bad_op ? '0 : alu_out;
                rsp_err_d   = bad_op;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule
